// File: rtl/mure_pkg.sv
// Shared trace-encoder definitions: instruction types, branch map sizing and
// the branch map accumulator control states.
package mure_pkg;

  localparam int unsigned ITYPE_LEN      = 3;
  localparam int unsigned BRANCH_MAP_LEN = 31;

  typedef enum logic [ITYPE_LEN-1:0] {
    ITYPE_NONE = 3'd0,
    EXC        = 3'd1,
    INT        = 3'd2,
    ERET       = 3'd3,
    NT_BRANCH  = 3'd4,
    TK_BRANCH  = 3'd5,
    UNINF_JUMP = 3'd6,
    ITYPE_RSVD = 3'd7
  } itype_e;

  typedef enum logic {
    EMPTY_OR_FILLING = 1'b0,
    FULL             = 1'b1
  } bma_state_e;

endpackage

// File: rtl/branch_map_accumulator.sv
// Collects taken/not-taken outcomes of retired conditional branches into a
// registered branch map; cleared by the packet emitter via flush_i.
module branch_map_accumulator
  import mure_pkg::*;
#(
  parameter int unsigned MAP_LEN = BRANCH_MAP_LEN,
  parameter int unsigned CNT_LEN = $clog2(MAP_LEN + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic [ITYPE_LEN-1:0] itype_i,
  input  logic                 flush_i,
  output logic [MAP_LEN-1:0]   branch_map_o,
  output logic [CNT_LEN-1:0]   branches_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 overflow_o
);

  logic [MAP_LEN-1:0] map_q, map_d;
  logic [CNT_LEN-1:0] branches_q, branches_d;
  logic               overflow_q, overflow_d;
  logic               branch_c;
  logic               not_taken_c;
  bma_state_e         state_c;

  assign branch_c    = valid_i && ((itype_i == NT_BRANCH) || (itype_i == TK_BRANCH));
  assign not_taken_c = (itype_i == NT_BRANCH);

  // Control state is a pure function of the count; no extra state flop.
  always_comb begin
    state_c = EMPTY_OR_FILLING;
    if (branches_q == CNT_LEN'(MAP_LEN)) begin
      state_c = FULL;
    end
  end

  // Flush takes effect first so a same-cycle branch lands at bit 0.
  always_comb begin
    map_d      = map_q;
    branches_d = branches_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      map_d      = '0;
      branches_d = '0;
      if (branch_c) begin
        map_d      = MAP_LEN'(not_taken_c);
        branches_d = CNT_LEN'(1);
      end
    end else if (branch_c) begin
      case (state_c)
        EMPTY_OR_FILLING: begin
          map_d      = map_q | (MAP_LEN'(not_taken_c) << branches_q);
          branches_d = branches_q + CNT_LEN'(1);
        end
        FULL: begin
          overflow_d = 1'b1;
        end
        default: begin
          overflow_d = overflow_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      map_q      <= '0;
      branches_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      map_q      <= map_d;
      branches_q <= branches_d;
      overflow_q <= overflow_d;
    end
  end

  assign branch_map_o = map_q;
  assign branches_o   = branches_q;
  assign overflow_o   = overflow_q;
  assign full_o       = (branches_q == CNT_LEN'(MAP_LEN));
  assign empty_o      = (branches_q == '0);

endmodule

// File: tb/tb_branch_map_accumulator.sv
// Self-checking bench for branch_map_accumulator: vector table plus
// hand-built fill/overflow/flush/reset sequences, checked through a queue.
module tb_branch_map_accumulator;

  localparam int unsigned MAP_LEN = 31;
  localparam int unsigned CNT_LEN = 5;

  typedef struct {
    logic [MAP_LEN-1:0] map;
    logic [CNT_LEN-1:0] cnt;
    logic               full;
    logic               empty;
    logic               ovf;
  } exp_t;

  typedef struct {
    logic       valid;
    logic [2:0] itype;
    logic       flush;
    exp_t       exp;
  } vec_t;

  logic               clk;
  logic               rst_n;
  logic               valid;
  logic [2:0]         itype;
  logic               flush;
  logic [MAP_LEN-1:0] map_o;
  logic [CNT_LEN-1:0] cnt_o;
  logic               full_o;
  logic               empty_o;
  logic               ovf_o;

  int   checks;
  int   failures;
  exp_t sb[$];
  vec_t tbl[12];

  branch_map_accumulator dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .valid_i     (valid),
    .itype_i     (itype),
    .flush_i     (flush),
    .branch_map_o(map_o),
    .branches_o  (cnt_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .overflow_o  (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [MAP_LEN-1:0] m, input logic [CNT_LEN-1:0] c,
                              input logic f, input logic e, input logic o);
    exp_t x;
    x.map = m; x.cnt = c; x.full = f; x.empty = e; x.ovf = o;
    return x;
  endfunction

  task automatic compare(input string name, input exp_t e);
    checks++;
    if (map_o !== e.map || cnt_o !== e.cnt || full_o !== e.full ||
        empty_o !== e.empty || ovf_o !== e.ovf) begin
      failures++;
      $display("FAIL %s: got map=%h cnt=%0d full=%b empty=%b ovf=%b, want map=%h cnt=%0d full=%b empty=%b ovf=%b",
               name, map_o, cnt_o, full_o, empty_o, ovf_o,
               e.map, e.cnt, e.full, e.empty, e.ovf);
    end
  endtask

  // Drive one cycle, queue its expectation, pop and compare after the edge.
  task automatic step(input string name, input logic v, input logic [2:0] it,
                      input logic fl, input exp_t e);
    exp_t got_e;
    @(negedge clk);
    valid = v; itype = it; flush = fl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got_e = sb.pop_front();
      compare(name, got_e);
    end
    valid = 1'b0; itype = 3'd0; flush = 1'b0;
  endtask

  initial begin
    logic [MAP_LEN-1:0] m;
    logic [MAP_LEN-1:0] ones;
    checks = 0; failures = 0;
    valid = 1'b0; itype = 3'd0; flush = 1'b0;
    rst_n = 1'b0;

    tbl[0]  = '{1'b1, 3'd1, 1'b0, mk(31'h0, 5'd0, 1'b0, 1'b1, 1'b0)};
    tbl[1]  = '{1'b1, 3'd2, 1'b0, mk(31'h0, 5'd0, 1'b0, 1'b1, 1'b0)};
    tbl[2]  = '{1'b1, 3'd3, 1'b0, mk(31'h0, 5'd0, 1'b0, 1'b1, 1'b0)};
    tbl[3]  = '{1'b1, 3'd6, 1'b0, mk(31'h0, 5'd0, 1'b0, 1'b1, 1'b0)};
    tbl[4]  = '{1'b0, 3'd4, 1'b0, mk(31'h0, 5'd0, 1'b0, 1'b1, 1'b0)};
    tbl[5]  = '{1'b1, 3'd5, 1'b0, mk(31'h0, 5'd1, 1'b0, 1'b0, 1'b0)};
    tbl[6]  = '{1'b1, 3'd4, 1'b0, mk(31'h2, 5'd2, 1'b0, 1'b0, 1'b0)};
    tbl[7]  = '{1'b1, 3'd4, 1'b0, mk(31'h6, 5'd3, 1'b0, 1'b0, 1'b0)};
    tbl[8]  = '{1'b1, 3'd7, 1'b0, mk(31'h6, 5'd3, 1'b0, 1'b0, 1'b0)};
    tbl[9]  = '{1'b0, 3'd5, 1'b0, mk(31'h6, 5'd3, 1'b0, 1'b0, 1'b0)};
    tbl[10] = '{1'b0, 3'd0, 1'b1, mk(31'h0, 5'd0, 1'b0, 1'b1, 1'b0)};
    tbl[11] = '{1'b0, 3'd0, 1'b1, mk(31'h0, 5'd0, 1'b0, 1'b1, 1'b0)};

    #12;
    compare("reset_values", mk(31'h0, 5'd0, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step($sformatf("table_%0d", i), tbl[i].valid, tbl[i].itype, tbl[i].flush, tbl[i].exp);
    end

    // Ten mixed branches, flush alone, then a single not-taken branch.
    m = '0;
    for (int i = 0; i < 10; i++) begin
      logic [2:0] it;
      it = (i % 3 == 0) ? 3'd5 : 3'd4;
      if (it == 3'd4) m[i] = 1'b1;
      step($sformatf("mix_%0d", i), 1'b1, it, 1'b0,
           mk(m, CNT_LEN'(i + 1), 1'b0, 1'b0, 1'b0));
    end
    step("flush_alone", 1'b0, 3'd0, 1'b1, mk(31'h0, 5'd0, 1'b0, 1'b1, 1'b0));
    step("after_flush", 1'b1, 3'd4, 1'b0, mk(31'h1, 5'd1, 1'b0, 1'b0, 1'b0));
    step("flush_clear", 1'b0, 3'd0, 1'b1, mk(31'h0, 5'd0, 1'b0, 1'b1, 1'b0));

    // Fill to capacity, then overflow.
    for (int i = 0; i < 31; i++) begin
      ones = '1;
      m = ones >> (30 - i);
      step($sformatf("fill_%0d", i), 1'b1, 3'd4, 1'b0,
           mk(m, CNT_LEN'(i + 1), (i == 30), 1'b0, 1'b0));
    end
    step("overflow_32", 1'b1, 3'd4, 1'b0, mk(31'h7FFFFFFF, 5'd31, 1'b1, 1'b0, 1'b1));
    step("overflow_33", 1'b1, 3'd5, 1'b0, mk(31'h7FFFFFFF, 5'd31, 1'b1, 1'b0, 1'b1));
    step("full_nonbranch", 1'b1, 3'd6, 1'b0, mk(31'h7FFFFFFF, 5'd31, 1'b1, 1'b0, 1'b1));
    step("full_flush_tk", 1'b1, 3'd5, 1'b1, mk(31'h0, 5'd1, 1'b0, 1'b0, 1'b1));
    step("flush_nt", 1'b1, 3'd4, 1'b1, mk(31'h1, 5'd1, 1'b0, 1'b0, 1'b1));
    step("append_tk", 1'b1, 3'd5, 1'b0, mk(31'h1, 5'd2, 1'b0, 1'b0, 1'b1));
    step("flush_pre17", 1'b0, 3'd0, 1'b1, mk(31'h0, 5'd0, 1'b0, 1'b1, 1'b1));

    // Count to 17, then asynchronous reset mid-cycle.
    for (int i = 0; i < 17; i++) begin
      ones = '1;
      m = ones >> (30 - i);
      step($sformatf("pre_rst_%0d", i), 1'b1, 3'd4, 1'b0,
           mk(m, CNT_LEN'(i + 1), 1'b0, 1'b0, 1'b1));
    end
    #2;
    rst_n = 1'b0;
    #1;
    compare("async_reset", mk(31'h0, 5'd0, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    step("resume_tk", 1'b1, 3'd5, 1'b0, mk(31'h0, 5'd1, 1'b0, 1'b0, 1'b0));
    step("resume_nt", 1'b1, 3'd4, 1'b0, mk(31'h2, 5'd2, 1'b0, 1'b0, 1'b0));

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
